iob_ila_dma_sink: RTL and testbench
===================================

# iob_ila_dma_sink

Stream-to-memory receiver for the ILA sample DMA stream. It accepts `DMA_TDATA_W`-wide beats on a valid/ready stream, buffers them in a small FIFO, and writes each beat to memory as `DMA_TDATA_W/DATA_W` consecutive words through an IOb-native master port. It sits between the ILA core's DMA output and the system interconnect, so a capture can be dumped to RAM without CPU reads of `SAMPLE_DATA`.

## Interface
- `DATA_W`, 32, IOb-native data width; word size in bytes is `DATA_W/8`.
- `ADDR_W`, 32, IOb-native byte address width.
- `DMA_TDATA_W`, 64, stream beat width. Must equal `R*DATA_W` with `R>=1`.
- `FIFO_DEPTH_W`, 3, FIFO holds `2**FIFO_DEPTH_W` beats.
- `clk_i`  in  1  system clock.
- `arst_n_i`  in  1  reset, asynchronous, active-low.
- `cke_i`  in  1  clock enable; when low, all state and outputs hold.
- `start_i`  in  1  one-cycle start request; sampled only in IDLE.
- `base_addr_i`  in  ADDR_W  byte address of the first word; latched on start.
- `n_beats_i`  in  16  number of beats to transfer; latched on start.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle completion pulse.
- `beats_done_o`  out  16  beats fully written in the current or last transfer.
- `tdata_i`  in  DMA_TDATA_W  stream data.
- `tvalid_i`  in  1  stream valid.
- `tready_o`  out  1  stream ready.
- `iob_avalid_o`  out  1  write request valid.
- `iob_addr_o`  out  ADDR_W  write byte address.
- `iob_wdata_o`  out  DATA_W  write data.
- `iob_wstrb_o`  out  DATA_W/8  write strobe. All ones while `iob_avalid_o` is high, zero otherwise.
- `iob_ready_i`  in  1  request accepted in this cycle.

## Operation
- **FSM states:** IDLE and RUN.
- **IDLE, start with nonzero count:** `start_i=1` and `n_beats_i!=0` latch `base_addr_i` and `n_beats_i`, clear `beats_done_o`, reset the accept counter and the word index, and go to RUN.
- **IDLE, start with zero count:** `start_i=1` and `n_beats_i=0` pulse `done_o` on the next cycle. The block stays in IDLE and issues no bus or stream activity.
- **`start_i` in RUN:** ignored.
- **Stream side:**
  - `tready_o = (state==RUN) && !fifo_full && (accepted < n_beats)`.
  - `tready_o` is a function of registers only and never depends on `tvalid_i`.
  - A beat is pushed when `tvalid_i && tready_o`.
  - `tvalid_i` in IDLE is never accepted. Beats beyond `n_beats` are not accepted.
- **Writer:**
  - While the FIFO is non-empty, the writer drives the head beat's slice `[k*DATA_W +: DATA_W]`, for word index k = 0..R-1, lowest slice first.
  - Write address = current address; it starts at the latched base.
  - On `iob_avalid_o && iob_ready_i`, address += `DATA_W/8` and k increments.
  - When k=R-1 completes, the head beat is popped, k returns to 0, and `beats_done_o` increments.
  - The head beat occupies a FIFO slot until it is popped.
- **Handshake rule:** once `iob_avalid_o` rises, `iob_avalid_o`, `iob_addr_o`, `iob_wdata_o` and `iob_wstrb_o` hold stable until the cycle in which `iob_ready_i=1`. No write is duplicated or dropped.
- **Address arithmetic:** modulo `2**ADDR_W`; it wraps silently. There is no alignment check.
- **Completion:** when the last word of beat `n_beats` is accepted, go to IDLE and pulse `done_o` on the next cycle. `beats_done_o` equals `n_beats` and holds until the next start.
- **Simultaneous push and pop:** allowed in the same cycle. The FIFO count stays unchanged, and a full FIFO with a pop in the same cycle still keeps `tready_o=0` for that cycle.

## Timing
- **Reset values:**
  - State IDLE.
  - `busy_o=0`, `done_o=0`, `beats_done_o=0`.
  - `tready_o=0`.
  - `iob_avalid_o=0`, `iob_addr_o=0`, `iob_wdata_o=0`, `iob_wstrb_o=0`.
  - FIFO empty.
- **Reset mid-transfer:** aborts immediately with all state cleared. No partial write is held.
- **Start latency:** `tready_o` can rise the cycle after `start_i`.
- **Write latency:** the FIFO write is registered, so the first `iob_avalid_o` for a beat rises no earlier than 1 cycle after its stream handshake.
- **Throughput:** with `iob_ready_i` constantly 1, one word per cycle, i.e. R cycles per beat with no bubbles between beats.
- **`done_o` timing:** `done_o` is registered and asserts exactly 1 cycle after the final write acceptance. `busy_o` is low in that same cycle.
- **`cke_i=0`:** freezes the FSM, counters, FIFO and all outputs. Handshakes seen during that cycle are not counted.

## Test plan
- **Basic transfer:** R=2, base 0x100, n=2, beats 0x1111_2222_3333_4444 then 0x5555_6666_7777_8888, `iob_ready_i=1`.
  - Required writes, in order: (0x100,0x33334444), (0x104,0x11112222), (0x108,0x77778888), (0x10C,0x55556666).
  - Then a single `done_o` pulse and `beats_done_o=2`.
- **Bus backpressure:** hold `iob_ready_i=0` for 3 cycles on word 1.
  - Address, data and strobe stay stable for all 3 cycles.
  - The word is written exactly once, and the total write count is unchanged.
- **FIFO full:** n=16, `iob_ready_i=0`, `tvalid_i=1`.
  - Exactly 8 beats are accepted, then `tready_o=0`.
  - Releasing `iob_ready_i` resumes acceptance, and all 32 words are written in order.
- **Zero-length start:** n=0.
  - `done_o` pulses 1 cycle later.
  - `tready_o` and `iob_avalid_o` stay 0 and `beats_done_o=0`.
- **Address wrap:** base 0xFFFF_FFFC, n=1, R=2 → write addresses 0xFFFF_FFFC then 0x0000_0000.
- **Reset and clock enable:**
  - Assert `arst_n_i=0` after 1 of 4 beats: all outputs take their reset values. A new start then completes normally from the new base.
  - Hold `cke_i=0` for 5 cycles mid-transfer: no state change, and the final write sequence is identical to the uninterrupted run.

Source files
------------

// File: rtl/iob_ila_dma_sink.sv
// iob_ila_dma_sink: receives DMA_TDATA_W-wide stream beats, buffers them in a
// small FIFO and writes each beat to memory as DMA_TDATA_W/DATA_W consecutive
// words through an IOb-native master port.
module iob_ila_dma_sink #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DMA_TDATA_W  = 64,
  parameter int FIFO_DEPTH_W = 3
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   cke_i,
  input  logic                   start_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [15:0]            n_beats_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            beats_done_o,
  input  logic [DMA_TDATA_W-1:0] tdata_i,
  input  logic                   tvalid_i,
  output logic                   tready_o,
  output logic                   iob_avalid_o,
  output logic [ADDR_W-1:0]      iob_addr_o,
  output logic [DATA_W-1:0]      iob_wdata_o,
  output logic [DATA_W/8-1:0]    iob_wstrb_o,
  input  logic                   iob_ready_i
);

  localparam int unsigned R     = DMA_TDATA_W / DATA_W;
  localparam int unsigned KW    = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_W;
  localparam int unsigned BYTES = DATA_W / 8;

  localparam logic [KW-1:0]         K_LAST   = KW'(R - 1);
  localparam logic [FIFO_DEPTH_W:0] CNT_FULL = (FIFO_DEPTH_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]       r_addr;
  logic [15:0]             r_n_beats;
  logic [15:0]             r_accepted;
  logic [15:0]             r_beats_done;
  logic [KW-1:0]           r_k;
  logic                    r_done;

  logic [DMA_TDATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_DEPTH_W-1:0] r_wptr;
  logic [FIFO_DEPTH_W-1:0] r_rptr;
  logic [FIFO_DEPTH_W:0]   r_count;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_start_go;
  logic                    w_start_zero;
  logic                    w_push;
  logic                    w_wr_acc;
  logic                    w_k_last;
  logic                    w_pop;
  logic                    w_last;
  logic [DMA_TDATA_W-1:0]  w_head;
  logic [DATA_W-1:0]       w_word;

  assign w_full       = (r_count == CNT_FULL);
  assign w_empty      = (r_count == '0);
  assign w_start_go   = (r_state == IDLE) && start_i && (n_beats_i != 16'd0);
  assign w_start_zero = (r_state == IDLE) && start_i && (n_beats_i == 16'd0);
  assign w_push       = tvalid_i && tready_o;
  assign w_wr_acc     = iob_avalid_o && iob_ready_i;
  assign w_k_last     = (r_k == K_LAST);
  assign w_pop        = w_wr_acc && w_k_last;
  assign w_last       = w_pop && ((r_beats_done + 16'd1) == r_n_beats);
  assign w_head       = r_mem[r_rptr];

  assign done_o       = r_done;
  assign beats_done_o = r_beats_done;

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
    end else if (cke_i) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and register-only handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    busy_o       = 1'b0;
    tready_o     = 1'b0;
    iob_avalid_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_go) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy_o       = 1'b1;
        tready_o     = !w_full && (r_accepted < r_n_beats);
        iob_avalid_o = !w_empty;
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the current word of the head beat, lowest slice first
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (r_k == KW'(i)) begin
        w_word = w_head[i*DATA_W +: DATA_W];
      end
    end
  end

  // Bus request fields, forced to zero whenever no request is pending
  always_comb begin
    iob_addr_o  = '0;
    iob_wdata_o = '0;
    iob_wstrb_o = '0;
    if (iob_avalid_o) begin
      iob_addr_o  = r_addr;
      iob_wdata_o = w_word;
      iob_wstrb_o = '1;
    end
  end

  // Transfer bookkeeping: address, counters, word index and done pulse
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_addr       <= '0;
      r_n_beats    <= '0;
      r_accepted   <= '0;
      r_beats_done <= '0;
      r_k          <= '0;
      r_done       <= 1'b0;
    end else if (cke_i) begin
      r_done <= w_start_zero || w_last;
      if (r_state == IDLE) begin
        // A zero-length start also clears the completed-beat count.
        if (start_i) begin
          r_beats_done <= '0;
          r_accepted   <= '0;
          r_k          <= '0;
        end
        if (w_start_go) begin
          r_addr    <= base_addr_i;
          r_n_beats <= n_beats_i;
        end
      end else begin
        if (w_push) begin
          r_accepted <= r_accepted + 16'd1;
        end
        if (w_wr_acc) begin
          r_addr <= r_addr + ADDR_W'(BYTES);
          if (w_k_last) begin
            r_k          <= '0;
            r_beats_done <= r_beats_done + 16'd1;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
      end
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_i) begin
    if (cke_i && w_push) begin
      r_mem[r_wptr] <= tdata_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (cke_i) begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_DEPTH_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_DEPTH_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_DEPTH_W + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_DEPTH_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_ila_dma_sink.sv
// Testbench for iob_ila_dma_sink: a stream driver feeds beats from a queue, a
// write monitor pops expected (address, data) pairs pushed when beats are queued.
module tb_iob_ila_dma_sink;

  logic        clk = 1'b0;
  logic        arst_n_i;
  logic        cke_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] n_beats_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] beats_done_o;
  logic [63:0] tdata_i  = '0;
  logic        tvalid_i = 1'b0;
  logic        tready_o;
  logic        iob_avalid_o;
  logic [31:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i;

  always #5 clk = ~clk;

  iob_ila_dma_sink #(
    .DATA_W(32),
    .ADDR_W(32),
    .DMA_TDATA_W(64),
    .FIFO_DEPTH_W(3)
  ) dut (
    .clk_i(clk),
    .arst_n_i(arst_n_i),
    .cke_i(cke_i),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .n_beats_i(n_beats_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .beats_done_o(beats_done_o),
    .tdata_i(tdata_i),
    .tvalid_i(tvalid_i),
    .tready_o(tready_o),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o(iob_addr_o),
    .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o),
    .iob_ready_i(iob_ready_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] beat_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = '0;

  int cyc          = 0;
  int wr_cnt       = 0;
  int acc_cnt      = 0;
  int done_cnt     = 0;
  int last_wr_cyc  = 0;
  int first_wr_cyc = 0;
  int wr_mark      = -1;

  always @(posedge clk) cyc++;

  // Stream driver: handshake sampled at negedge, queue advanced after posedge
  always begin : drv
    bit hs;
    @(negedge clk);
    hs = tvalid_i && tready_o && cke_i && arst_n_i;
    if (hs) acc_cnt++;
    @(posedge clk);
    #1;
    if (hs && beat_q.size() > 0) beat_q.delete(0);
    if (beat_q.size() > 0) begin
      tvalid_i = 1'b1;
      tdata_i  = beat_q[0];
    end else begin
      tvalid_i = 1'b0;
      tdata_i  = '0;
    end
  end

  // Write monitor / scoreboard
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (arst_n_i && cke_i) begin
      if (iob_avalid_o && iob_ready_i) begin
        if (wr_cnt == wr_mark) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: got addr=%h data=%h, required no write", iob_addr_o, iob_wdata_o);
        end else begin
          e = exp_q.pop_front();
          if ({iob_addr_o, iob_wdata_o, iob_wstrb_o} !== {e, 4'hF}) begin
            n_err++;
            $display("FAIL write_seq: got addr=%h data=%h strb=%h, required addr=%h data=%h strb=f",
                     iob_addr_o, iob_wdata_o, iob_wstrb_o, e[63:32], e[31:0]);
          end
        end
      end
      if (done_o) done_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic push_beat(input logic [63:0] d);
    beat_q.push_back(d);
    exp_q.push_back({exp_addr, d[31:0]});
    exp_addr = exp_addr + 32'd4;
    exp_q.push_back({exp_addr, d[63:32]});
    exp_addr = exp_addr + 32'd4;
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] n);
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; n_beats_i = n;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
  endtask

  task automatic wait_wr(input int target, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (wr_cnt >= target) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1 arst_n_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_o, done_o, beats_done_o, tready_o, iob_avalid_o} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy=%b done=%b beats=%0d tready=%b avalid=%b, required all 0",
               busy_o, done_o, beats_done_o, tready_o, iob_avalid_o);
    end
    n_cmp++;
    if ({iob_addr_o, iob_wdata_o, iob_wstrb_o} !== '0) begin
      n_err++;
      $display("FAIL reset_bus: got addr=%h data=%h strb=%h, required 0", iob_addr_o, iob_wdata_o, iob_wstrb_o);
    end
    @(posedge clk); #1 arst_n_i = 1'b1;
  endtask

  task automatic test_zero_len();
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    pulse_start(32'h40, 16'd0);
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++; $display("FAIL zero_done: got done=%b, required 1", done_o);
    end
    n_cmp++;
    if ({tready_o, iob_avalid_o, busy_o, beats_done_o} !== '0) begin
      n_err++;
      $display("FAIL zero_quiet: got tready=%b avalid=%b busy=%b beats=%0d, required 0",
               tready_o, iob_avalid_o, busy_o, beats_done_o);
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++; $display("FAIL zero_pulse_len: got done=%b, required 0", done_o);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 != 1 || wr_cnt != w0) begin
      n_err++; $display("FAIL zero_counts: got dones=%0d writes=%0d, required 1 and 0", done_cnt - d0, wr_cnt - w0);
    end
  endtask

  task automatic test_basic();
    int a0, w0, d0;
    bit seen;
    @(posedge clk); #1 iob_ready_i = 1'b1;
    @(negedge clk);
    exp_addr = 32'h100;
    push_beat(64'h1111_2222_3333_4444);
    push_beat(64'h5555_6666_7777_8888);
    a0 = acc_cnt;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (acc_cnt != a0 || tready_o !== 1'b0) begin
      n_err++; $display("FAIL idle_no_accept: got accepted=%0d tready=%b, required 0 and 0", acc_cnt - a0, tready_o);
    end
    w0 = wr_cnt; d0 = done_cnt; wr_mark = wr_cnt;
    pulse_start(32'h100, 16'd2);
    wait_done(40, seen);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL basic_done_timeout: got no done, required done within 40 cycles");
    end
    n_cmp++;
    if (cyc != last_wr_cyc + 1 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL basic_done_timing: got delay=%0d busy=%b, required 1 and 0", cyc - last_wr_cyc, busy_o);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (beats_done_o !== 16'd2 || done_cnt - d0 != 1) begin
      n_err++; $display("FAIL basic_count: got beats=%0d dones=%0d, required 2 and 1", beats_done_o, done_cnt - d0);
    end
    n_cmp++;
    if (wr_cnt - w0 != 4 || exp_q.size() != 0) begin
      n_err++; $display("FAIL basic_writes: got %0d writes, %0d pending, required 4 and 0", wr_cnt - w0, exp_q.size());
    end
    n_cmp++;
    if (last_wr_cyc - first_wr_cyc != 3) begin
      n_err++; $display("FAIL basic_throughput: got span=%0d cycles, required 3", last_wr_cyc - first_wr_cyc);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    bit seen;
    @(posedge clk); #1 iob_ready_i = 1'b0;
    @(negedge clk);
    exp_addr = 32'h200;
    push_beat(64'hAAAA_0001_BBBB_0002);
    push_beat(64'hCCCC_0003_DDDD_0004);
    w0 = wr_cnt;
    pulse_start(32'h200, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (iob_avalid_o) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL bp_avalid_timeout: got avalid=0, required 1 within 20 cycles");
    end
    @(posedge clk); #1 iob_ready_i = 1'b1;
    @(posedge clk); #1 iob_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o} !== {1'b1, 32'h204, 32'hAAAA_0001, 4'hF}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got avalid=%b addr=%h data=%h strb=%h, required 1 00000204 aaaa0001 f",
                 i, iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o);
      end
    end
    @(posedge clk); #1 iob_ready_i = 1'b1;
    wait_done(40, seen);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!seen || wr_cnt - w0 != 4 || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_writes: got done=%b writes=%0d pending=%0d, required 1, 4, 0", seen, wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_fifo_full();
    int a0, w0;
    bit seen;
    @(posedge clk); #1 iob_ready_i = 1'b0;
    @(negedge clk);
    exp_addr = 32'h1000;
    for (int i = 0; i < 16; i++) begin
      push_beat({32'hA000_0001 + 32'(2 * i), 32'hA000_0000 + 32'(2 * i)});
    end
    a0 = acc_cnt; w0 = wr_cnt;
    pulse_start(32'h1000, 16'd16);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (acc_cnt - a0 != 8 || tready_o !== 1'b0 || wr_cnt != w0) begin
      n_err++; $display("FAIL full_stall: got accepted=%0d tready=%b writes=%0d, required 8, 0, 0",
                        acc_cnt - a0, tready_o, wr_cnt - w0);
    end
    @(posedge clk); #1 iob_ready_i = 1'b1;
    wait_done(100, seen);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL full_done_timeout: got no done, required done within 100 cycles");
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wr_cnt - w0 != 32 || exp_q.size() != 0 || acc_cnt - a0 != 16 || beats_done_o !== 16'd16) begin
      n_err++; $display("FAIL full_drain: got writes=%0d pending=%0d accepted=%0d beats=%0d, required 32, 0, 16, 16",
                        wr_cnt - w0, exp_q.size(), acc_cnt - a0, beats_done_o);
    end
  endtask

  task automatic test_wrap();
    int w0;
    bit seen;
    @(negedge clk);
    exp_addr = 32'hFFFF_FFFC;
    push_beat(64'h0123_4567_89AB_CDEF);
    w0 = wr_cnt;
    pulse_start(32'hFFFF_FFFC, 16'd1);
    wait_done(30, seen);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!seen || wr_cnt - w0 != 2 || exp_q.size() != 0 || beats_done_o !== 16'd1) begin
      n_err++; $display("FAIL wrap: got done=%b writes=%0d pending=%0d beats=%0d, required 1, 2, 0, 1",
                        seen, wr_cnt - w0, exp_q.size(), beats_done_o);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit seen;
    @(negedge clk);
    exp_addr = 32'h300;
    for (int i = 0; i < 4; i++) push_beat({32'hB000_0001 + 32'(2 * i), 32'hB000_0000 + 32'(2 * i)});
    w0 = wr_cnt;
    pulse_start(32'h300, 16'd4);
    wait_wr(w0 + 2, 30, seen);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL rst_mid_timeout: got %0d writes, required 2 within 30 cycles", wr_cnt - w0);
    end
    @(posedge clk); #1 arst_n_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_o, done_o, beats_done_o, tready_o, iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b beats=%0d tready=%b avalid=%b addr=%h data=%h strb=%h, required all 0",
               busy_o, done_o, beats_done_o, tready_o, iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o);
    end
    beat_q.delete();
    exp_q.delete();
    @(posedge clk); #1 arst_n_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_addr = 32'h400;
    push_beat(64'hC000_0011_C000_0010);
    push_beat(64'hC000_0013_C000_0012);
    w0 = wr_cnt;
    pulse_start(32'h400, 16'd2);
    wait_done(40, seen);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!seen || wr_cnt - w0 != 4 || exp_q.size() != 0 || beats_done_o !== 16'd2) begin
      n_err++; $display("FAIL rst_restart: got done=%b writes=%0d pending=%0d beats=%0d, required 1, 4, 0, 2",
                        seen, wr_cnt - w0, exp_q.size(), beats_done_o);
    end
  endtask

  task automatic test_cke();
    int w0;
    bit seen;
    logic [83:0] snap;
    logic [83:0] now;
    @(negedge clk);
    exp_addr = 32'h500;
    for (int i = 0; i < 4; i++) push_beat({32'hD000_0001 + 32'(2 * i), 32'hD000_0000 + 32'(2 * i)});
    w0 = wr_cnt;
    pulse_start(32'h500, 16'd4);
    wait_wr(w0 + 3, 30, seen);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL cke_timeout: got %0d writes, required 3 within 30 cycles", wr_cnt - w0);
    end
    @(posedge clk); #1 cke_i = 1'b0;
    @(negedge clk);
    snap = {busy_o, tready_o, iob_avalid_o, iob_addr_o, iob_wdata_o, beats_done_o, done_o};
    n_cmp++;
    if (busy_o !== 1'b1 || iob_avalid_o !== 1'b1) begin
      n_err++; $display("FAIL cke_active: got busy=%b avalid=%b, required 1 and 1", busy_o, iob_avalid_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      now = {busy_o, tready_o, iob_avalid_o, iob_addr_o, iob_wdata_o, beats_done_o, done_o};
      n_cmp++;
      if (now !== snap) begin
        n_err++; $display("FAIL cke_freeze[%0d]: got %h, required %h", i, now, snap);
      end
    end
    @(posedge clk); #1 cke_i = 1'b1;
    wait_done(40, seen);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!seen || wr_cnt - w0 != 8 || exp_q.size() != 0 || beats_done_o !== 16'd4) begin
      n_err++; $display("FAIL cke_resume: got done=%b writes=%0d pending=%0d beats=%0d, required 1, 8, 0, 4",
                        seen, wr_cnt - w0, exp_q.size(), beats_done_o);
    end
  endtask

  initial begin
    arst_n_i    = 1'b0;
    cke_i       = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    n_beats_i   = '0;
    iob_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_zero_len();
    test_basic();
    test_backpressure();
    test_fifo_full();
    test_wrap();
    test_reset_mid();
    test_cke();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
